// File: rtl/radiant_event_hdr_reader_pkg.sv
// Shared types and constants for the event header reader: FSM states, header layout
// and the wishbone address helper for a header dword.
package radiant_event_hdr_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_PUSH = 3'd2,
        ST_DONE = 3'd3,
        ST_GAP  = 3'd4,
        ST_HALT = 3'd5
    } evhdr_state_e;

    localparam logic [31:0] EVHDR_IDENTIFIER = 32'h52444530;
    localparam int          EVHDR_NUM_DWORDS = 8;

    typedef enum logic [2:0] {
        IDENT    = 3'd0,
        SEC      = 3'd1,
        COUNT    = 3'd2,
        SYSCLK   = 3'd3,
        INFO     = 3'd4,
        STATUS   = 3'd5,
        LAST     = 3'd6,
        LASTLAST = 3'd7
    } evhdr_dword_e;

    function automatic logic [8:0] evhdr_dword_adr(input logic [8:0] base, input logic [2:0] idx);
        return base + {4'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/radiant_event_hdr_reader_if.sv
// Wishbone classic read/write bus between the header reader (master) and the
// event control core (slave).
interface radiant_event_hdr_reader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [8:0]  adr;
    logic [31:0] dat_rd;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (output cyc, stb, we, adr, input dat_rd, ack, err, rty);
    modport slave  (input cyc, stb, we, adr, output dat_rd, ack, err, rty);
endinterface

// File: rtl/radiant_event_hdr_reader_wb_read_single.sv
// Single wishbone read with timeout. Strobe is registered and dropped on the edge
// after the terminating cycle; done/abort are same-cycle qualifiers for the caller.
module evhdr_wb_read_single #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [8:0]  adr,
    output logic [31:0] data,
    output logic        done,
    output logic        abort,
    radiant_event_hdr_reader_if.master wbm
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic       busy_r;
    logic [8:0] adr_r;
    logic [7:0] tmo_r;

    // Termination decode; the strobe cycle that finds the count at TIMEOUT_CYCLES-1 is the last one allowed.
    always_comb begin
        abort = busy_r && (wbm.err || wbm.rty || ((tmo_r == TMO_LAST) && !wbm.ack));
        done  = busy_r && wbm.ack && !wbm.err && !wbm.rty;
    end

    // Bus cycle and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r <= 1'b0;
            adr_r  <= 9'd0;
            tmo_r  <= 8'd0;
        end else if (busy_r) begin
            if (done || abort) begin
                busy_r <= 1'b0;
            end else begin
                tmo_r <= tmo_r + 8'd1;
            end
        end else if (start) begin
            busy_r <= 1'b1;
            adr_r  <= adr;
            tmo_r  <= 8'd0;
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign wbm.cyc = busy_r;
    assign wbm.stb = busy_r;
    assign wbm.we  = 1'b0;
    assign wbm.adr = adr_r;
    assign data    = wbm.dat_rd;

endmodule

// File: rtl/radiant_event_hdr_reader.sv
// Drains 8-dword event headers over wishbone into a valid/ready stream, then pops the
// DMA-request FIFO. Optional identifier check on dword 0 under EVHDR_ID_CHECK_EN.
module radiant_event_hdr_reader
    import radiant_event_hdr_reader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [8:0] BASE_ADR       = 9'h100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        err_clear_i,
    radiant_event_hdr_reader_if.master wbm,
    input  logic        event_ready_i,
    input  logic        event_ready_type_i,
    output logic        event_readout_ready_o,
    output logic [31:0] hdr_tdata_o,
    output logic        hdr_tvalid_o,
    input  logic        hdr_tready_i,
    output logic        hdr_tlast_o,
    output logic        hdr_type_o,
    output logic [15:0] hdr_count_o,
    output logic        halted_o,
    output logic        id_err_o
);

    evhdr_state_e state_r, state_nx;
    logic [2:0]   k_r;
    logic         gap_r;
    logic [31:0]  tdata_r;
    logic         tvalid_r, tlast_r, type_r, readout_r, halted_r, id_err_r;
    logic [15:0]  count_r;

    logic         rd_start_s, rd_done_s, rd_abort_s, push_hs_s, last_s;
    logic [8:0]   rd_adr_s;
    logic [31:0]  rd_data_s;

    evhdr_wb_read_single #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (rd_start_s),
        .adr   (rd_adr_s),
        .data  (rd_data_s),
        .done  (rd_done_s),
        .abort (rd_abort_s),
        .wbm   (wbm)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: state_nx = (event_ready_i && enable_i) ? ST_RD : ST_IDLE;
            ST_RD: begin
                if (rd_abort_s) begin
                    state_nx = ST_HALT;
                end else if (rd_done_s) begin
                    state_nx = ST_PUSH;
                end else begin
                    state_nx = ST_RD;
                end
            end
            ST_PUSH: begin
                if (push_hs_s) begin
                    state_nx = last_s ? ST_DONE : ST_RD;
                end else begin
                    state_nx = ST_PUSH;
                end
            end
            ST_DONE: state_nx = ST_GAP;
            ST_GAP:  state_nx = gap_r ? ST_IDLE : ST_GAP;
            ST_HALT: state_nx = err_clear_i ? ST_IDLE : ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read launch: a read starts on every edge that enters RD.
    always_comb begin
        push_hs_s  = tvalid_r && hdr_tready_i;
        last_s     = (k_r == LASTLAST);
        rd_start_s = 1'b0;
        rd_adr_s   = evhdr_dword_adr(BASE_ADR, IDENT);
        if (state_r == ST_IDLE && state_nx == ST_RD) begin
            rd_start_s = 1'b1;
        end else if (state_r == ST_PUSH && state_nx == ST_RD) begin
            rd_start_s = 1'b1;
            rd_adr_s   = evhdr_dword_adr(BASE_ADR, k_r + 3'd1);
        end else begin
            rd_start_s = 1'b0;
        end
    end

    // Stream register, dword index, counters and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_r       <= 3'd0;
            gap_r     <= 1'b0;
            tdata_r   <= 32'd0;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            type_r    <= 1'b0;
            readout_r <= 1'b0;
            halted_r  <= 1'b0;
            count_r   <= 16'd0;
        end else begin
            readout_r <= (state_nx == ST_DONE);
            halted_r  <= (state_nx == ST_HALT);
            case (state_r)
                ST_IDLE: begin
                    if (state_nx == ST_RD) begin
                        k_r    <= IDENT;
                        type_r <= event_ready_type_i;
                    end
                end
                ST_RD: begin
                    if (rd_done_s) begin
                        tdata_r  <= rd_data_s;
                        tvalid_r <= 1'b1;
                        tlast_r  <= last_s;
                    end
                end
                ST_PUSH: begin
                    if (push_hs_s) begin
                        tvalid_r <= 1'b0;
                        tlast_r  <= 1'b0;
                        if (!last_s) begin
                            k_r <= k_r + 3'd1;
                        end
                    end
                end
                ST_DONE: count_r <= count_r + 16'd1;
                ST_GAP:  gap_r   <= ~gap_r;
                default: gap_r   <= 1'b0;
            endcase
        end
    end

`ifdef EVHDR_ID_CHECK_EN
    // Sticky identifier mismatch; the header still streams so the slave FIFOs stay aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_err_r <= 1'b0;
        end else if (err_clear_i) begin
            id_err_r <= 1'b0;
        end else if (state_r == ST_RD && rd_done_s && k_r == IDENT && rd_data_s != EVHDR_IDENTIFIER) begin
            id_err_r <= 1'b1;
        end else begin
            id_err_r <= id_err_r;
        end
    end
`else
    assign id_err_r = 1'b0;
`endif

    assign event_readout_ready_o = readout_r;
    assign hdr_tdata_o           = tdata_r;
    assign hdr_tvalid_o          = tvalid_r;
    assign hdr_tlast_o           = tlast_r;
    assign hdr_type_o            = type_r;
    assign hdr_count_o           = count_r;
    assign halted_o              = halted_r;
    assign id_err_o              = id_err_r;

endmodule

// File: tb/tb_radiant_event_hdr_reader.sv
// Self-checking bench for radiant_event_hdr_reader: vector table, random headers
// against a stream model, and hand-written back-to-back/timeout/reset sequences.
module tb_radiant_event_hdr_reader;
    import radiant_event_hdr_reader_pkg::*;

    localparam int         TMO  = 16;
    localparam logic [8:0] BASE = 9'h100;
`ifdef EVHDR_ID_CHECK_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, err_clear = 1'b0;
    logic event_ready = 1'b0, event_type = 1'b0, tready = 1'b1;
    logic readout, hdr_tvalid, hdr_tlast, hdr_type, halted, id_err;
    logic [31:0] hdr_tdata;
    logic [15:0] hdr_count;

    radiant_event_hdr_reader_if bus();

    radiant_event_hdr_reader #(.TIMEOUT_CYCLES(TMO), .BASE_ADR(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .err_clear_i(err_clear), .wbm(bus),
        .event_ready_i(event_ready), .event_ready_type_i(event_type),
        .event_readout_ready_o(readout), .hdr_tdata_o(hdr_tdata), .hdr_tvalid_o(hdr_tvalid),
        .hdr_tready_i(tready), .hdr_tlast_o(hdr_tlast), .hdr_type_o(hdr_type),
        .hdr_count_o(hdr_count), .halted_o(halted), .id_err_o(id_err)
    );

    always #5 clk = ~clk;

    // Slave: registered ack one cycle after strobe; reads of dwords 1-7 pop the FIFOs.
    logic [31:0] mem [8];
    int noack_idx = -1;
    int pops = 0;
    always @(posedge clk) begin
        if (rst) bus.ack <= 1'b0;
        else     bus.ack <= bus.cyc && bus.stb && !bus.ack && (int'(bus.adr[4:2]) != noack_idx);
        bus.dat_rd <= mem[bus.adr[4:2]];
        if (bus.cyc && bus.stb && bus.ack && bus.adr != BASE) pops++;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Monitor on the falling edge.
    logic [31:0] got_q[$];
    logic        last_q[$];
    int pulses = 0, pulse_cyc = 0, starts = 0, start_cyc = 0, run = 0, last_run = 0;
    int hold_viol = 0, stb_viol = 0;
    logic prev_hold = 1'b0, prev_ack = 1'b0, prev_cyc = 1'b0;
    logic [31:0] prev_data = 32'd0;
    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_tvalid && tready) begin got_q.push_back(hdr_tdata); last_q.push_back(hdr_tlast); end
            if (readout) begin pulses++; pulse_cyc = cyc_cnt; end
            if (bus.cyc && !prev_cyc && bus.adr == BASE) begin starts++; start_cyc = cyc_cnt; end
            if (bus.cyc) run++;
            else begin if (run > 0) last_run = run; run = 0; end
            if (hdr_tvalid && !tready) begin
                if (bus.cyc) hold_viol++;
                if (prev_hold && hdr_tdata != prev_data) hold_viol++;
            end
            if (prev_ack && bus.stb) stb_viol++;
        end
        prev_hold = hdr_tvalid && !tready;
        prev_data = hdr_tdata;
        prev_ack  = bus.ack;
        prev_cyc  = bus.cyc;
    end

    // Consumer ready: held high, random, or a stall window armed after N dwords.
    int stall_at = -1, stall_len = 0, stall_left = 0;
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (stall_at >= 0 && got_q.size() == stall_at) begin stall_left = stall_len; stall_at = -1; end
        if (stall_left > 0) begin tready = 1'b0; stall_left--; end
        else tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int checks = 0, failures = 0;
    logic [15:0] exp_count = 16'd0;
    logic        exp_id = 1'b0;
    int t0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic clear_mon();
        got_q.delete(); last_q.delete();
        pulses = 0; pops = 0; starts = 0; hold_viol = 0; start_cyc = 0;
    endtask

    // One header with event_ready dropped at the pop; the model is the raw dword list.
    task automatic run_hdr(input logic [31:0] dw [8], input logic typ, input int stall,
                           input int exp_lat, input string tag);
        int lat, b;
        logic [31:0] g;
        logic l;
        for (int i = 0; i < 8; i++) mem[i] = dw[i];
        clear_mon();
        if (stall != 0) begin stall_len = 12; stall_at = 3; end
        event_type = typ; event_ready = 1'b1; t0 = cyc_cnt;
        b = 0;
        while (pulses == 0 && b < 300) begin tick(1); b++; end
        event_ready = 1'b0;
        lat = (pulses == 0) ? -1 : pulse_cyc - t0;
        tick(4);
        exp_count = exp_count + 16'd1;
        if (ID_EN && dw[0] != EVHDR_IDENTIFIER) exp_id = 1'b1;
        if (exp_lat >= 0) begin
            chk({tag, " start"}, 64'(start_cyc - t0), 64'd1);
            chk({tag, " readout_latency"}, 64'(lat), 64'(exp_lat));
        end
        chk({tag, " ndwords"}, 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            l = (i < last_q.size()) ? last_q[i] : 1'bx;
            chk({tag, " tdata"}, 64'(g), 64'(dw[i]));
            chk({tag, " tlast"}, 64'(l), 64'(i == 7));
        end
        chk({tag, " pulses"}, 64'(pulses), 64'd1);
        chk({tag, " pops"}, 64'(pops), 64'd7);
        chk({tag, " count"}, 64'(hdr_count), 64'(exp_count));
        chk({tag, " type"}, 64'(hdr_type), 64'(typ));
        chk({tag, " id_err"}, 64'(id_err), 64'(exp_id));
        chk({tag, " hold"}, 64'(hold_viol), 64'd0);
    endtask

    typedef struct {
        logic [31:0] dw [8];
        logic        typ;
        int          stall;
        int          exp_lat;
    } vec_t;
    vec_t vecs [4];
    logic [31:0] rdw [8];
    int b;

    initial begin
        bus.err = 1'b0; bus.rty = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vecs[0].dw[i] = (i == 0) ? EVHDR_IDENTIFIER : 32'(i);
            vecs[1].dw[i] = (i == 0) ? EVHDR_IDENTIFIER : 32'(i);
            vecs[2].dw[i] = (i == 0) ? 32'hDEADBEEF : 32'h1000 + 32'(i);
            vecs[3].dw[i] = (i == 0) ? EVHDR_IDENTIFIER : ((i % 2 == 1) ? 32'hFFFFFFFF : 32'hA5A5A5A5 ^ 32'(i));
        end
        vecs[0].typ = 1'b0; vecs[0].stall = 0; vecs[0].exp_lat = 25;
        vecs[1].typ = 1'b1; vecs[1].stall = 1; vecs[1].exp_lat = 35;
        vecs[2].typ = 1'b0; vecs[2].stall = 0; vecs[2].exp_lat = 25;
        vecs[3].typ = 1'b1; vecs[3].stall = 0; vecs[3].exp_lat = 25;

        // Reset state.
        tick(3);
        chk("rst cyc", 64'(bus.cyc), 64'd0);
        chk("rst stb", 64'(bus.stb), 64'd0);
        chk("rst we", 64'(bus.we), 64'd0);
        chk("rst adr", 64'(bus.adr), 64'd0);
        chk("rst tvalid", 64'(hdr_tvalid), 64'd0);
        chk("rst tdata", 64'(hdr_tdata), 64'd0);
        chk("rst count", 64'(hdr_count), 64'd0);
        chk("rst readout", 64'(readout), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);
        chk("rst id_err", 64'(id_err), 64'd0);
        rst = 1'b0; enable = 1'b1;
        tick(2);

        for (int v = 0; v < 4; v++) run_hdr(vecs[v].dw, vecs[v].typ, vecs[v].stall, vecs[v].exp_lat, $sformatf("vec%0d", v));

        // Random headers with random consumer back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) rdw[i] = $urandom;
            if ($urandom_range(0, 3) != 0) rdw[0] = EVHDR_IDENTIFIER;
            run_hdr(rdw, 1'($urandom_range(0, 1)), 0, -1, $sformatf("rand%0d", r));
        end
        rand_ready = 1'b0;
        tick(2);

        // Back-to-back headers with event_ready held; enable dropped mid-second header.
        for (int i = 0; i < 8; i++) mem[i] = vecs[0].dw[i];
        clear_mon();
        event_ready = 1'b1; t0 = cyc_cnt;
        b = 0;
        while (starts < 2 && b < 300) begin tick(1); b++; end
        chk("b2b start_gap", 64'(start_cyc - t0), 64'd29);
        tick(5);
        enable = 1'b0;
        b = 0;
        while (pulses < 2 && b < 300) begin tick(1); b++; end
        tick(12);
        exp_count = exp_count + 16'd2;
        chk("b2b pulses", 64'(pulses), 64'd2);
        chk("b2b count", 64'(hdr_count), 64'(exp_count));
        chk("b2b ndwords", 64'(got_q.size()), 64'd16);
        chk("b2b no_third", 64'(starts), 64'd2);
        event_ready = 1'b0; enable = 1'b1;
        tick(2);

        // Slave never acks dword 5: timeout, HALT, then err_clear.
        clear_mon();
        noack_idx = 5; event_ready = 1'b1;
        b = 0;
        while (!halted && b < 300) begin tick(1); b++; end
        chk("tmo halted", 64'(halted), 64'd1);
        chk("tmo cyc_len", 64'(last_run), 64'(TMO));
        chk("tmo ndwords", 64'(got_q.size()), 64'd5);
        tick(5);
        chk("tmo idle_bus", 64'(bus.cyc), 64'd0);
        chk("tmo no_restart", 64'(starts), 64'd1);
        chk("tmo pulses", 64'(pulses), 64'd0);
        chk("tmo count", 64'(hdr_count), 64'(exp_count));
        event_ready = 1'b0; noack_idx = -1;
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        exp_id = 1'b0;
        chk("clr halted", 64'(halted), 64'd0);
        chk("clr id_err", 64'(id_err), 64'd0);
        tick(2);
        run_hdr(vecs[0].dw, 1'b0, 0, 25, "after_clear");

        // Reset during the dword 4 read.
        clear_mon();
        event_ready = 1'b1;
        b = 0;
        while (!(bus.cyc && bus.adr == BASE + 9'd16) && b < 300) begin tick(1); b++; end
        rst = 1'b1;
        tick(1);
        chk("mrst cyc", 64'(bus.cyc), 64'd0);
        chk("mrst tvalid", 64'(hdr_tvalid), 64'd0);
        chk("mrst count", 64'(hdr_count), 64'd0);
        chk("mrst pulses", 64'(pulses), 64'd0);
        rst = 1'b0; event_ready = 1'b0;
        exp_count = 16'd0; exp_id = 1'b0;
        tick(2);
        run_hdr(vecs[0].dw, 1'b1, 0, 25, "after_rst");

        chk("stb_after_ack", 64'(stb_viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radiant_event_hdr_reader.md
# radiant_event_hdr_reader

Wishbone master that drains event headers from the event control core's header FIFO window (0x100–0x11C) whenever a header is pending. It streams the eight header dwords out on a valid/ready interface with a last marker, then pulses the readout-ready strobe so the control core pops its DMA-request FIFO. It sits between the event control core's wishbone slave port and the downstream header consumer, such as the DMA packer or the readout bridge.

## Interface
- TIMEOUT_CYCLES, 255: cycles to wait for ack before aborting; range 1–255.
- BASE_ADR, 9'h100: wishbone address of header dword 0.
- clk_i  in  1  wishbone clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  permit starting new headers.
- err_clear_i  in  1  single-cycle pulse; clears sticky errors and leaves HALT.
- wbm_cyc_o, wbm_stb_o  out  1  wishbone master cycle/strobe.
- wbm_we_o  out  1  constant 0.
- wbm_adr_o  out  9  byte address.
- wbm_dat_i  in  32  read data.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave termination.
- event_ready_i  in  1  header pending (DMA-request FIFO valid).
- event_ready_type_i  in  1  event type of the pending header.
- event_readout_ready_o  out  1  one-cycle pop strobe to the DMA-request FIFO.
- hdr_tdata_o  out  32  header dword.
- hdr_tvalid_o  out  1  dword valid.
- hdr_tready_i  in  1  consumer ready.
- hdr_tlast_o  out  1  high with dword 7.
- hdr_type_o  out  1  event type, latched at header start.
- hdr_count_o  out  16  completed headers; wraps at 0xFFFF→0.
- halted_o  out  1  in HALT state.
- id_err_o  out  1  sticky identifier mismatch.

## Operation
- States: IDLE, RD, PUSH, DONE, GAP, HALT.
- IDLE: when event_ready_i && enable_i, latch hdr_type_o, set k=0, go to RD.
- RD: cyc=stb=1 and adr=BASE_ADR+4k.
  - On ack: capture wbm_dat_i into hdr_tdata_o, set tvalid, drop cyc/stb on the next edge, go to PUSH.
  - Strobe must never be held past the ack cycle, because each acked read of dwords 1–7 pops a slave FIFO.
- PUSH: hold tdata/tvalid until tready.
  - On handshake with k<7: k++, go to RD.
  - On handshake with k==7: go to DONE.
  - tlast = (k==7).
- DONE: event_readout_ready_o=1 for exactly one cycle; hdr_count_o++ (wrapping). Go to GAP.
- GAP: two idle cycles so the request FIFO's valid can update, then IDLE. Back-to-back headers are allowed.
- Abort conditions, checked in RD: wbm_err_i, wbm_rty_i, or the timeout counter reaching TIMEOUT_CYCLES without ack.
  - Drop cyc/stb and go to HALT; halted_o=1.
  - Do not pulse readout-ready; the partial header's already-pushed dwords stand.
- HALT: no bus activity. err_clear_i returns the block to IDLE and clears id_err_o.
- enable_i low mid-header does not stop the header; the current header completes.
- Reset values: all outputs 0, state IDLE, k=0, count 0.
- Reset mid-header: cyc drops at the next edge with no readout-ready pulse.

## Timing
- IDLE with event_ready_i → cyc high on the next cycle.
- Slave ack arrives 1 cycle after stb.
- tvalid rises the cycle after ack, with cyc low in that cycle. This gap cycle is required because the slave's ack is registered.
- With tready held high: 3 cycles per dword, 24 cycles for the header.
- Readout-ready pulse comes on the cycle after the dword-7 handshake.
- Event-ready to next-header start is 28 cycles minimum.
- Timeout counter is 8 bits, cleared on RD entry, increments each RD cycle without ack.

## Configuration
- EVHDR_ID_CHECK_EN defined: dword 0 is compared against 0x52444530 ("RDE0").
  - A mismatch sets id_err_o (sticky).
  - The header is still streamed and popped, so the slave FIFOs stay aligned.
- EVHDR_ID_CHECK_EN undefined: no comparator; id_err_o tied 0.

## Structure
- Shared package holds:
  - the state enum;
  - EVHDR_IDENTIFIER = 32'h52444530;
  - EVHDR_NUM_DWORDS = 8;
  - the dword index names (IDENT, SEC, COUNT, SYSCLK, INFO, STATUS, LAST, LASTLAST).
- One natural sub-module, evhdr_wb_read_single: a single-read wishbone master with timeout, returning data/done/abort. The top holds the state machine and stream register.

## Test plan
- Single header, tready=1, slave dwords 0x52444530, 1, 2, …, 7:
  - stream emits those 8 values with tlast on the 8th;
  - exactly 7 slave FIFO pops;
  - one readout-ready pulse 25 cycles after start;
  - hdr_count_o=1.
- tready low for 10 cycles on dword 3: tdata stays 3; no new cyc until the handshake; the header completes unchanged.
- Slave never acks dword 5 with TIMEOUT_CYCLES=16:
  - cyc drops after 16 cycles; halted_o=1; no readout-ready pulse;
  - err_clear_i returns the block to IDLE.
- Dword 0 = 0xDEADBEEF with EVHDR_ID_CHECK_EN: id_err_o=1; all 8 dwords are streamed; readout-ready pulses.
- Two pending events, event_ready_i held: two headers back-to-back with 2 GAP cycles; hdr_count_o=2. Dropping enable_i mid-second header still completes it.
- rst_i asserted during dword 4 RD: next cycle cyc=0, tvalid=0, count=0, state IDLE.
